// File: rtl/sd_block_responder.sv
`timescale 1ns/1ps
// sd_block_responder: block-RAM backed stand-in for the SD card controller's
// user-side port. Answers rd/wr block commands with the controller's
// ready / byte_available / ready_for_next_byte handshake and byte pacing.
module sd_block_responder #(
    parameter int NUM_BLOCKS  = 16,
    parameter int BYTE_PERIOD = 32,
    parameter int CMD_LATENCY = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] address,
    input  logic        rd,
    input  logic        wr,
    output logic        ready,
    output logic [7:0]  dout,
    output logic        byte_available,
    input  logic [7:0]  din,
    output logic        ready_for_next_byte,
    output logic        addr_error
);
    localparam int BW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int LW = (CMD_LATENCY > 1) ? $clog2(CMD_LATENCY) : 1;
    localparam int SW = $clog2(BYTE_PERIOD);

    localparam logic [LW-1:0] LAT_LAST  = LW'(CMD_LATENCY - 1);
    localparam logic [LW-1:0] LAT_PRE   = LW'((CMD_LATENCY > 1) ? CMD_LATENCY - 2 : 0);
    localparam logic [SW-1:0] SLOT_LAST = SW'(BYTE_PERIOD - 1);
    localparam logic [SW-1:0] SLOT_PRE  = SW'(BYTE_PERIOD - 2);
    localparam logic [SW-1:0] HALF      = SW'(BYTE_PERIOD / 2);
    localparam logic [SW-1:0] HALF_LAST = SW'(BYTE_PERIOD / 2 - 1);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_RD_WAIT, S_RD_BYTE, S_WR_WAIT, S_WR_BYTE, S_WR_COMMIT
    } state_e;

    state_e        state_q, state_d;
    logic [LW-1:0] lat_cnt_q;
    logic [SW-1:0] slot_cnt_q;
    logic [8:0]    byte_cnt_q;
    logic [BW-1:0] blk_q;
    logic          err_q;
    logic [7:0]    dout_q;

    // Not reset: contents survive reset and start at zero from configuration.
    logic [7:0]    mem [NUM_BLOCKS*512];

    logic lat_done, slot_last, byte_last, accept, req_oob;
    logic unused_addr_bits;

    assign lat_done  = (lat_cnt_q == LAT_LAST);
    assign slot_last = (slot_cnt_q == SLOT_LAST);
    assign byte_last = (byte_cnt_q == 9'd511);
    assign accept    = (state_q == S_IDLE) && (rd || wr);
    assign req_oob   = (address[31:9] >= 23'(NUM_BLOCKS));
    assign unused_addr_bits = ^address[8:0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_INIT;
        else        state_q <= state_d;
    end

    // Next-state: rd wins over wr; byte phases end after slot 511
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:      if (lat_done) state_d = S_IDLE;
            S_IDLE:      if (rd) state_d = S_RD_WAIT;
                         else if (wr) state_d = S_WR_WAIT;
            S_RD_WAIT:   if (lat_done) state_d = S_RD_BYTE;
            S_RD_BYTE:   if (slot_last && byte_last) state_d = S_IDLE;
            S_WR_WAIT:   if (lat_done) state_d = S_WR_BYTE;
            S_WR_BYTE:   if (slot_last && byte_last) state_d = S_WR_COMMIT;
            S_WR_COMMIT: if (lat_done) state_d = S_IDLE;
            default:     state_d = S_INIT;
        endcase
    end

    // Handshake outputs decoded from registered state and slot position
    always_comb begin
        ready               = 1'b0;
        byte_available      = 1'b0;
        ready_for_next_byte = 1'b0;
        case (state_q)
            S_IDLE:    ready = 1'b1;
            S_RD_BYTE: byte_available = (slot_cnt_q < HALF);
            S_WR_BYTE: ready_for_next_byte = (slot_cnt_q < HALF);
            default: ;
        endcase
    end

    assign dout       = dout_q;
    assign addr_error = err_q;

    // Latency, slot and byte counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_cnt_q  <= '0;
            slot_cnt_q <= '0;
            byte_cnt_q <= '0;
        end else begin
            case (state_q)
                S_INIT, S_RD_WAIT, S_WR_WAIT, S_WR_COMMIT:
                    lat_cnt_q <= lat_done ? '0 : lat_cnt_q + 1'b1;
                default: lat_cnt_q <= '0;
            endcase
            if (state_q == S_RD_BYTE || state_q == S_WR_BYTE) begin
                slot_cnt_q <= slot_last ? '0 : slot_cnt_q + 1'b1;
                if (slot_last) byte_cnt_q <= byte_cnt_q + 1'b1;
            end else begin
                slot_cnt_q <= '0;
            end
            if (accept) byte_cnt_q <= '0;
        end
    end

    // Command latch: block index and sticky range flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_q <= '0;
            err_q <= 1'b0;
        end else if (accept) begin
            blk_q <= address[9 +: BW];
            err_q <= req_oob;
        end
    end

    // Read prefetch lands in dout one cycle before each byte_available rise
    logic          fetch;
    logic [BW-1:0] fetch_blk;
    logic [8:0]    fetch_byte;
    logic          fetch_oob;

    always_comb begin
        fetch      = 1'b0;
        fetch_blk  = blk_q;
        fetch_byte = 9'(byte_cnt_q + 9'd1);
        fetch_oob  = err_q;
        case (state_q)
            // with a one-cycle wait the fetch for byte 0 happens on acceptance
            S_IDLE: begin
                fetch      = accept && rd && (CMD_LATENCY == 1);
                fetch_blk  = address[9 +: BW];
                fetch_byte = '0;
                fetch_oob  = req_oob;
            end
            S_RD_WAIT: begin
                fetch      = (CMD_LATENCY > 1) && (lat_cnt_q == LAT_PRE);
                fetch_byte = '0;
            end
            S_RD_BYTE: fetch = (slot_cnt_q == SLOT_PRE) && !byte_last;
            default: ;
        endcase
    end

    // Read data register; out-of-range blocks read as zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     dout_q <= 8'h00;
        else if (fetch) dout_q <= fetch_oob ? 8'h00 : mem[{fetch_blk, fetch_byte}];
    end

    // Write port: din captured on the last high cycle of each request pulse
    always_ff @(posedge clk) begin
        if (state_q == S_WR_BYTE && slot_cnt_q == HALF_LAST && !err_q)
            mem[{blk_q, byte_cnt_q}] <= din;
    end

endmodule

// File: tb/tb_sd_block_responder.sv
`timescale 1ns/1ps
// tb_sd_block_responder: scoreboard bench. Expected read bytes are queued from
// a RAM model when a read is issued and popped on each byte_available rise.
// Byte period and latency are shortened to keep the run short; all timing
// expectations are written in terms of BP and LAT.
module tb_sd_block_responder;
    localparam int NB     = 16;
    localparam int BP     = 8;
    localparam int LAT    = 16;
    localparam int RD_LEN = 1 + LAT + 512*BP;
    localparam int WR_LEN = 1 + 2*LAT + 512*BP;
    localparam int LIMIT  = WR_LEN + 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] address = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [7:0]  din = '0;
    logic        ready, byte_available, ready_for_next_byte, addr_error;
    logic [7:0]  dout;

    sd_block_responder #(.NUM_BLOCKS(NB), .BYTE_PERIOD(BP), .CMD_LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .address(address), .rd(rd), .wr(wr),
        .ready(ready), .dout(dout), .byte_available(byte_available), .din(din),
        .ready_for_next_byte(ready_for_next_byte), .addr_error(addr_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;
    logic [7:0] model   [NB*512];
    logic [7:0] wr_data [512];
    logic [7:0] exp_q   [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_ready();
        for (int c = 0; c < LIMIT; c++) begin
            if (ready === 1'b1) return;
            @(negedge clk);
        end
        chk("wait_ready", 32'(ready), 32'd1);
    endtask

    // Called at a negedge; releases reset and measures time to ready
    task automatic release_reset();
        int c0;
        logic noisy = 1'b0;
        rst_n = 1'b1;
        c0 = cyc;
        for (int c = 0; c < LIMIT; c++) begin
            @(negedge clk);
            if (byte_available || ready_for_next_byte || addr_error || dout != 8'h00) noisy = 1'b1;
            if (ready) break;
        end
        chk("init_latency", 32'(cyc - c0), 32'(LAT));
        chk("init_quiet", 32'(noisy), 32'd0);
    endtask

    task automatic issue(input logic [31:0] a, input logic r, input logic w,
                         input logic exp_err, output int t_acc);
        wait_ready();
        address = a; rd = r; wr = w;
        t_acc = cyc + 1;
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
        chk("ready_fall", 32'(ready), 32'd0);
        chk("addr_error", 32'(addr_error), 32'(exp_err));
    endtask

    task automatic read_blk(input logic [31:0] a, input logic w_too);
        int t, base;
        int n = 0, t_first = 0, t_last = 0, t_rdy = 0;
        logic ba_d = 1'b0, rf_seen = 1'b0, oob;
        logic [7:0] dout_d, e;
        oob  = (a[31:9] >= 23'(NB));
        base = int'(a[12:9]) * 512;
        for (int k = 0; k < 512; k++) exp_q.push_back(oob ? 8'h00 : model[base + k]);
        issue(a, 1'b1, w_too, oob, t);
        dout_d = dout;
        for (int c = 0; c < LIMIT; c++) begin
            if (ready) begin t_rdy = cyc + 1; break; end
            if (ready_for_next_byte) rf_seen = 1'b1;
            if (byte_available && !ba_d) begin
                if (n == 0) t_first = cyc + 1;
                t_last = cyc + 1;
                n++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("dout", 32'(dout), 32'(e));
                    chk("dout_setup", 32'(dout_d), 32'(e));
                end
            end
            ba_d = byte_available;
            dout_d = dout;
            @(negedge clk);
        end
        chk("rd_ready", 32'(ready), 32'd1);
        chk("rd_bytes", 32'(n), 32'd512);
        chk("rd_first_t", 32'(t_first), 32'(t + 1 + LAT));
        chk("rd_last_t", 32'(t_last), 32'(t + 1 + LAT + 511*BP));
        chk("rd_ready_t", 32'(t_rdy), 32'(t + RD_LEN));
        chk("sb_left", 32'(exp_q.size()), 32'd0);
        chk("rd_no_wreq", 32'(rf_seen), 32'd0);
        chk("rd_addr_err", 32'(addr_error), 32'(oob));
        exp_q.delete();
    endtask

    // stop_at < 512: return at the negedge where pulse stop_at-1 has ended
    task automatic write_blk(input logic [31:0] a, input int stop_at);
        int t, base;
        int nr = 0, nf = 0, t_first = 0, t_rdy = 0;
        logic rf_d = 1'b0, oob;
        logic partial;
        partial = (stop_at < 512);
        oob  = (a[31:9] >= 23'(NB));
        base = int'(a[12:9]) * 512;
        issue(a, 1'b0, 1'b1, oob, t);
        for (int c = 0; c < LIMIT; c++) begin
            if (ready_for_next_byte && !rf_d) begin
                if (nr == 0) t_first = cyc + 1;
                if (nr < 512) din = wr_data[nr];
                nr++;
            end
            if (!ready_for_next_byte && rf_d) nf++;
            if (partial && nf == stop_at) break;
            if (ready) begin t_rdy = cyc + 1; break; end
            rf_d = ready_for_next_byte;
            @(negedge clk);
        end
        chk("wr_first_t", 32'(t_first), 32'(t + 1 + LAT));
        if (partial) begin
            chk("wr_partial", 32'(nf), 32'(stop_at));
        end else begin
            chk("wr_ready", 32'(ready), 32'd1);
            chk("wr_pulses", 32'(nr), 32'd512);
            chk("wr_ready_t", 32'(t_rdy), 32'(t + WR_LEN));
            chk("wr_addr_err", 32'(addr_error), 32'(oob));
        end
        if (!oob)
            for (int k = 0; k < nf && k < 512; k++) model[base + k] = wr_data[k];
    endtask

    initial begin
        for (int k = 0; k < NB*512; k++) model[k] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_ba", 32'(byte_available), 32'd0);
        chk("rst_rfnb", 32'(ready_for_next_byte), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_addr_err", 32'(addr_error), 32'd0);
        release_reset();

        // write then read block 2 (address 0x400) with din = k
        for (int k = 0; k < 512; k++) wr_data[k] = 8'(k);
        write_blk(32'h400, 512);
        read_blk(32'h400, 1'b0);

        // block 0 gets its own pattern
        for (int k = 0; k < 512; k++) wr_data[k] = 8'(k*7 + 3);
        write_blk(32'h0, 512);

        // out of range: read zeros, write discarded, flag clears on next read
        read_blk(32'h2000, 1'b0);
        for (int k = 0; k < 512; k++) wr_data[k] = 8'hEE;
        write_blk(32'h2000, 512);
        read_blk(32'h0, 1'b0);

        // rd and wr together: read wins, din never taken
        din = 8'hC3;
        read_blk(32'h400, 1'b1);

        // reset after write byte 99 of block 2
        for (int k = 0; k < 512; k++) wr_data[k] = 8'(k) ^ 8'h5A;
        write_blk(32'h400, 100);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(ready), 32'd0);
        chk("mid_rst_rfnb", 32'(ready_for_next_byte), 32'd0);
        chk("mid_rst_ba", 32'(byte_available), 32'd0);
        chk("mid_rst_dout", 32'(dout), 32'd0);
        chk("mid_rst_addr_err", 32'(addr_error), 32'd0);
        repeat (2) @(negedge clk);
        release_reset();
        read_blk(32'h400, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: run did not complete, checks %0d errors %0d", n_chk, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
